// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NREQ producers, the write arbiter and the FIFO write port.
// The arbiter uses the slave side; whoever drives requests and the full flag uses master.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req_i;
  logic [NREQ*DW-1:0] req_data_i;
  logic               fifo_full_i;
  logic [NREQ-1:0]    gnt_o;
  logic [NREQ-1:0]    ack_o;
  logic               fifo_wr_o;
  logic [DW-1:0]      fifo_data_o;
  logic               busy_o;

  modport slave (
    input  req_i, req_data_i, fifo_full_i,
    output gnt_o, ack_o, fifo_wr_o, fifo_data_o, busy_o
  );

  modport master (
    output req_i, req_data_i, fifo_full_i,
    input  gnt_o, ack_o, fifo_wr_o, fifo_data_o, busy_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, granting
// bursts of up to BURST_MAX beats and stalling while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_MAX - 1);
  localparam logic [PW-1:0] LAST_REQ  = PW'(NREQ - 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [PW-1:0]   rr_q, rr_d;

  logic [PW-1:0]   win_idx;
  logic            win_vld;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   rr_after;
  logic            req_g;
  logic            wr;
  logic [DW-1:0]   data_mux;
  logic [DW-1:0]   slice_masked [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign slice_masked[gi] = gnt_q[gi] ? bus.req_data_i[gi*DW +: DW] : '0;
  end

  // Scan from the highest offset down so the closest requester to rr_q wins last.
  always_comb begin
    int          idx;
    logic [PW-1:0] cand;
    idx     = 0;
    cand    = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = PW'(idx);
      if (bus.req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_idx  = '0;
    data_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) gnt_idx = PW'(i);
      data_mux = data_mux | slice_masked[i];
    end
  end

  assign rr_after = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + PW'(1);
  assign req_g    = |(gnt_q & bus.req_i);
  assign wr       = (state_q == ST_GRANT) && req_g && !bus.fifo_full_i;

  assign bus.gnt_o       = gnt_q;
  assign bus.ack_o       = gnt_q & {NREQ{wr}};
  assign bus.fifo_wr_o   = wr;
  assign bus.fifo_data_o = data_mux;
  assign bus.busy_o      = (state_q == ST_GRANT);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    beat_d  = beat_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          beat_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A dropped request ends the burst even mid-stall; a full FIFO just holds.
        if (!req_g || (wr && beat_q == LAST_BEAT)) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          rr_d    = rr_after;
        end else if (wr) begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      beat_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      beat_q  <= beat_d;
      rr_q    <= rr_d;
    end
  end
endmodule
